// File: rtl/da2.sv
// da2: dual-channel serial transmitter for the Pmod DA2 (two DAC121S101).
// Both 16-bit frames {2'b00, pd, data} are shifted out MSB-first in
// parallel on a shared SCLK/SYNC, with SCLK derived from the system clock.
module da2 #(
   parameter int CLK_DIV     = 2,
   parameter int IDLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        update,
   input  logic [11:0] dataA,
   input  logic [11:0] dataB,
   input  logic [1:0]  pdA,
   input  logic [1:0]  pdB,
   output logic        SCLK,
   output logic        SYNC,
   output logic        DINA,
   output logic        DINB,
   output logic        busy
);

   localparam int DW = $clog2(CLK_DIV + 1);
   localparam int HW = $clog2(IDLE_CYCLES + 1);
   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(IDLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t        state;
   logic [DW-1:0] div_cnt;
   logic [4:0]    edge_cnt;   // SCLK transitions issued in this frame (0..31)
   logic [HW-1:0] hold_cnt;
   logic [14:0]   sr_a;       // bits still to be sent; bit 15 goes straight to DIN
   logic [14:0]   sr_b;

   logic [15:0] frame_a;
   logic [15:0] frame_b;
   logic        hold_done;
   logic        start;

   assign frame_a   = {2'b00, pdA, dataA};
   assign frame_b   = {2'b00, pdB, dataB};
   assign hold_done = (state == HOLD) && (hold_cnt == HOLD_LAST);
   // The last HOLD cycle doubles as an IDLE sample so a held update
   // repeats every 32*CLK_DIV + IDLE_CYCLES cycles.
   assign start     = update && ((state == IDLE) || hold_done);

   // Frame sequencer: load, SCLK generation and shifting, post-frame hold.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         SCLK     <= 1'b1;
         SYNC     <= 1'b1;
         DINA     <= 1'b0;
         DINB     <= 1'b0;
         busy     <= 1'b0;
         sr_a     <= '0;
         sr_b     <= '0;
         div_cnt  <= '0;
         edge_cnt <= '0;
         hold_cnt <= '0;
      end else if (start) begin
         sr_a     <= frame_a[14:0];
         sr_b     <= frame_b[14:0];
         DINA     <= frame_a[15];
         DINB     <= frame_b[15];
         SYNC     <= 1'b0;
         SCLK     <= 1'b1;
         busy     <= 1'b1;
         div_cnt  <= '0;
         edge_cnt <= '0;
         state    <= SHIFT;
      end else begin
         case (state)
            SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (edge_cnt == 5'd31) begin
                     // CLK_DIV cycles after the 16th falling edge: close the frame.
                     SCLK     <= 1'b1;
                     SYNC     <= 1'b1;
                     hold_cnt <= '0;
                     state    <= HOLD;
                  end else begin
                     edge_cnt <= edge_cnt + 5'd1;
                     SCLK     <= ~SCLK;
                     // Rising transition: present the next bit, both lanes together.
                     if (!SCLK) begin
                        DINA <= sr_a[14];
                        DINB <= sr_b[14];
                        sr_a <= {sr_a[13:0], 1'b0};
                        sr_b <= {sr_b[13:0], 1'b0};
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end
            HOLD: begin
               if (hold_done) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/da2.md
# da2

Transmit-side serial interface for the Pmod DA2, which carries two DAC121S101 12-bit DACs on a shared SCLK/SYNC with separate data lines. It latches two 12-bit samples and two power-down codes on an update request and shifts both 16-bit frames out MSB-first in parallel, generating SCLK internally from the system clock. It is the output-direction counterpart of the AD1 ADC reader in the Pmod library and sits between a sample source (DDS, test pattern, ADC loopback) and the Pmod header.

## Interface
- CLK_DIV, 2, system clock cycles per SCLK half-period; legal range ≥1. The default gives SCLK = clk/4, which is 25 MHz at 100 MHz.
- IDLE_CYCLES, 4, system clock cycles that SYNC stays high after a frame before the next frame may start; legal range ≥1.
- clk  in  1  system clock; all logic runs on the rising edge.
- rst  in  1  synchronous, active-low reset.
- update  in  1  level request to send a frame; sampled only in IDLE.
- dataA  in  12  channel A sample, unsigned.
- dataB  in  12  channel B sample, unsigned.
- pdA  in  2  channel A power-down code.
- pdB  in  2  channel B power-down code.
- SCLK  out  1  serial clock to the DACs; idles high.
- SYNC  out  1  frame sync, active-low.
- DINA  out  1  serial data to DAC A.
- DINB  out  1  serial data to DAC B.
- busy  out  1  high while a frame or the post-frame hold is in progress.

## Operation
- Frame format, per channel, sent MSB first:
  - bits [15:14] = 2'b00
  - bits [13:12] = pd code
  - bits [11:0] = data
- State machine states: IDLE, SHIFT, HOLD.
- IDLE:
  - Outputs: SYNC=1, SCLK=1, busy=0.
  - DINA/DINB hold their last value (0 after reset).
  - On a clk edge with update=1:
    - Latch {2'b00,pdA,dataA} and {2'b00,pdB,dataB} into two 16-bit shift registers.
    - Drive SYNC=0 and busy=1, and present bit 15 on DINA/DINB.
    - Clear the half-period counter and the bit counter, then go to SHIFT.
- SHIFT:
  - SCLK toggles each time the half-period counter reaches CLK_DIV.
  - On each SCLK rising transition, the shift registers advance and the next bit appears on DINA/DINB. The DAC samples on SCLK falling edges.
  - After the 16th falling edge, wait CLK_DIV cycles, then drive SCLK=1 and SYNC=1 on the same edge and go to HOLD.
- HOLD:
  - busy stays 1 and SYNC stays 1 for IDLE_CYCLES cycles, then go to IDLE.
- Input stability:
  - dataA/dataB/pdA/pdB changes after the latch edge do not affect the frame in flight.
  - update asserted outside IDLE is ignored; no queuing.
- update held high gives back-to-back frames.
- Reset (rst=0 at a clk edge), including mid-frame:
  - Next state is IDLE.
  - SYNC=1, SCLK=1, DINA=DINB=0, busy=0, shift registers cleared.
  - A truncated frame (SYNC rising before the 16th falling edge) is aborted by the DAC. This is acceptable.
- Reset has priority over update.

## Timing
- Let T0 be the clk edge that accepts update. All timings below are for CLK_DIV=N.
- SYNC falls and busy rises at T0. Bit 15 is valid at T0.
- SCLK falling edge k (k=1..16) occurs at T0 + (2k−1)·N cycles.
- SCLK rising edge k (k=1..15) occurs at T0 + 2k·N. Bit 15−k is presented on the same edge.
- SCLK returns high and SYNC rises at T0 + 32·N.
- busy falls at T0 + 32·N + IDLE_CYCLES.
- The next frame may be accepted on that same edge, if update=1, for a repeat period of 32·N + IDLE_CYCLES cycles.
- Data setup before each falling edge is N clk cycles; data hold after it is N cycles.
- For the defaults, the frame lasts 64 cycles and busy is high for 68 cycles.
- DINA and DINB always change on the same clk edge. The two channels are never skewed.

## Test plan
- Reset, then idle: hold rst=0 for 2 cycles, then release with update=0 for 20 cycles.
  - Required: SCLK=1, SYNC=1, DINA=DINB=0, busy=0 throughout.
- Single frame: defaults, dataA=12'hA5C, pdA=2'b00, dataB=12'h3F1, pdB=2'b01, one-cycle update pulse.
  - Sample DINA/DINB on SCLK falling edges: 16'h0A5C and 16'h13F1.
  - Exactly 16 falling edges occur while SYNC=0.
  - SYNC is low for 64 cycles; busy is high for 68 cycles.
- Ignored request and input change: pulse update again 10 cycles into the frame, and change dataA to 12'hFFF.
  - Required: the frame still carries 16'h0A5C.
  - No second frame starts after busy falls.
- Continuous update with CLK_DIV=1 and IDLE_CYCLES=1:
  - Successive SYNC falling edges are 33 cycles apart.
  - SYNC is high for exactly 1 cycle between frames.
- Mid-frame reset: assert rst=0 after the 7th falling edge.
  - Required: on the next edge SYNC=1, SCLK=1, DINA=DINB=0, busy=0.
  - A following update produces a complete, correct frame.
- Boundary values: dataA=12'h000 with pdA=2'b11, and dataB=12'hFFF with pdB=2'b00.
  - Captured frames: 16'h3000 and 16'h0FFF.
